// File: rtl/fir_pkg.sv
// Shared types and constants for the 4-tap FIR filter.
package fir_pkg;

  localparam int DATA_W = 16;
  localparam int NTAPS  = 4;

  typedef logic signed [DATA_W-1:0] sample_t;

  // Default coefficients: taps x[t], x[t-1], x[t-2], x[t-3].
  localparam sample_t COEF0 = 16'sd2;
  localparam sample_t COEF1 = 16'sd3;
  localparam sample_t COEF2 = -16'sd2;
  localparam sample_t COEF3 = 16'sd8;

endpackage

// File: rtl/fir_delay_line.sv
// N-deep register chain with asynchronous active-low clear.
// taps[k*W +: W] holds the input delayed by k+1 clocks.
module fir_delay_line #(
  parameter int N = 3,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   din,
  output logic [N*W-1:0] taps
);

  logic [W-1:0] stage_reg  [N];
  logic [W-1:0] stage_next [N];

  // Each stage loads from its predecessor; the head loads the new sample.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_next[gi] = din;
      end else begin : g_link
        assign stage_next[gi] = stage_reg[gi-1];
      end
      assign taps[gi*W +: W] = stage_reg[gi];
    end
  endgenerate

  // Shift the chain every edge; clear the whole history at once on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) stage_reg[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) stage_reg[i] <= stage_next[i];
    end
  end

endmodule

// File: rtl/fir4_filter.sv
// 4-tap direct-form FIR: result = C0*x[t] + C1*x[t-1] + C2*x[t-2] + C3*x[t-3],
// combinational from arg, wrapping modulo 2^DATA_W.
module fir4_filter #(
  parameter int                       DATA_W = fir_pkg::DATA_W,
  parameter logic signed [DATA_W-1:0] C0     = DATA_W'(fir_pkg::COEF0),
  parameter logic signed [DATA_W-1:0] C1     = DATA_W'(fir_pkg::COEF1),
  parameter logic signed [DATA_W-1:0] C2     = DATA_W'(fir_pkg::COEF2),
  parameter logic signed [DATA_W-1:0] C3     = DATA_W'(fir_pkg::COEF3)
) (
  input  logic                     system1000,
  input  logic                     system1000_rstn,
  input  logic signed [DATA_W-1:0] arg,
  output logic signed [DATA_W-1:0] result
);

  localparam int NT = fir_pkg::NTAPS;

  logic [(NT-1)*DATA_W-1:0]  hist;
  logic signed [DATA_W-1:0]  tap  [NT];
  logic signed [DATA_W-1:0]  coef [NT];
  logic signed [DATA_W-1:0]  sum_next;

  fir_delay_line #(
    .N (NT-1),
    .W (DATA_W)
  ) u_delay (
    .clk   (system1000),
    .rst_n (system1000_rstn),
    .din   (arg),
    .taps  (hist)
  );

  // Tap 0 is the live input; the rest come from the delay line.
  assign tap[0] = arg;
  generate
    for (genvar gi = 1; gi < NT; gi++) begin : g_tap
      assign tap[gi] = $signed(hist[(gi-1)*DATA_W +: DATA_W]);
    end
  endgenerate

  assign coef[0] = C0;
  assign coef[1] = C1;
  assign coef[2] = C2;
  assign coef[3] = C3;

  // Dot product at DATA_W width: the low DATA_W bits of a product or sum
  // never depend on higher bits, so this equals the truncated exact sum.
  always_comb begin
    sum_next = '0;
    for (int k = 0; k < NT; k++) begin
      sum_next = sum_next + coef[k] * tap[k];
    end
  end

  assign result = sum_next;

endmodule

// File: tb/tb_fir4_filter.sv
// Directed, table-driven bench for fir4_filter.
module tb_fir4_filter;
  import fir_pkg::*;

  logic    clk;
  logic    rstn;
  sample_t arg;
  sample_t result;

  int n_total;
  int n_pass;

  typedef struct {
    bit      do_rst;  // pulse reset (off-edge) before applying this sample
    sample_t arg;
    sample_t exp;
    string   name;
  } vec_t;

  vec_t vecs [$];

  fir4_filter dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .arg             (arg),
    .result          (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: timeout, act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input sample_t act, input sample_t exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %-14s result=%0d expected=%0d", name, act, exp);
    end else begin
      $display("FAIL %-14s result=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic add(input bit r, input int a, input int e, input string n);
    vec_t v;
    v.do_rst = r;
    v.arg    = sample_t'(a);
    v.exp    = sample_t'(e);
    v.name   = n;
    vecs.push_back(v);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;

    // Stimulus ROM sequence and output checker values.
    add(1,  2,  4, "rom0");
    add(0,  3, 12, "rom1");
    add(0, -2,  1, "rom2");
    add(0,  8, 20, "rom3");
    // Impulse response equals the coefficient list.
    add(1,  1,  2, "imp0");
    add(0,  0,  3, "imp1");
    add(0,  0, -2, "imp2");
    add(0,  0,  8, "imp3");
    add(0,  0,  0, "imp4");
    add(0,  0,  0, "imp5");
    // Positive full scale: wraps, steady state 360437 mod 65536 = 32757.
    add(1, 32767,    -2, "pmax0");
    add(0, 32767, 32763, "pmax1");
    add(0, 32767, 32765, "pmax2");
    add(0, 32767, 32757, "pmax3");
    add(0, 32767, 32757, "pmax4");
    // Negative full scale: 11*(-32768) wraps to -32768, never saturated.
    add(1, -32768,      0, "nmax0");
    add(0, -32768, -32768, "nmax1");
    add(0, -32768, -32768, "nmax2");
    add(0, -32768, -32768, "nmax3");
    add(0, -32768, -32768, "nmax4");

    // Reset state: history is zero, result follows C0*arg.
    rstn = 1'b0;
    arg  = 16'sd5;
    #2;
    check("rst_comb", result, 16'sd10);
    @(posedge clk); #1;
    arg = -16'sd3;
    #2;
    check("rst_hold", result, -16'sd6);
    @(negedge clk);
    rstn = 1'b1;

    // Table: drive just after a rising edge, check mid-cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      if (vecs[i].do_rst) begin
        rstn = 1'b0;
        #1;
        rstn = 1'b1;
      end
      arg = vecs[i].arg;
      #3;
      check(vecs[i].name, result, vecs[i].exp);
    end

    // Off-edge asynchronous reset clears the history immediately.
    @(posedge clk); #1;
    rstn = 1'b0; #1; rstn = 1'b1;
    arg = 16'sd2;
    @(posedge clk); #1; arg = 16'sd3;
    @(posedge clk); #1; arg = -16'sd2;
    @(posedge clk); #1; arg = 16'sd8;
    @(posedge clk); #1; arg = 16'sd0;
    #2;
    check("hist_loaded", result, 16'sd52);
    #1;
    rstn = 1'b0;
    #1;
    check("async_clear", result, 16'sd0);
    rstn = 1'b1;
    arg  = 16'sd7;
    #1;
    check("restart0", result, 16'sd14);
    @(posedge clk); #1;
    arg = 16'sd0;
    #2;
    check("restart1", result, 16'sd21);

    // Combinational path: mid-cycle input change shows up the same cycle.
    @(posedge clk); #1;
    rstn = 1'b0; #1; rstn = 1'b1;
    arg = 16'sd5;
    #1;
    check("comb_a", result, 16'sd10);
    arg = -16'sd7;
    #1;
    check("comb_b", result, -16'sd14);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
